fnd_scan_controller: RTL and testbench
======================================

// Module: fnd_scan_controller
// PURPOSE
//  Time-multiplexes one shared 8-bit segment bus across four common-anode FND digits to show 0..9999.
//  Owns its own scan prescaler. Converts a 14-bit binary value to BCD with a sequential double-dabble
//  engine once per frame and drives registered, active-low digit-select and segment outputs.
//  Sits between the counter/value source and the board FND pins.
// PARAMETERS
//  SCAN_DIV         100_000  i_clk cycles per digit slot (1 kHz digit rate @100 MHz); legal range >= 16
//  LEAD_ZERO_BLANK  0        1 = blank leading zero digits; 0 = always show four digits
// PORTS
//  i_clk         in   1   system clock
//  i_reset       in   1   asynchronous, active-high reset
//  i_enable      in   1   1 = scan running; 0 = display dark
//  i_value       in   14  binary value to display
//  o_fnd_com     out  4   digit select, active-low one-hot; bit0 = ones digit
//  o_fnd_font    out  8   segments {dp,g,f,e,d,c,b,a}, active-low; dp is always 1 (off)
//  o_overflow    out  1   1 while the committed frame value was clamped (i_value > 9999)
//  o_busy        out  1   1 while the BCD conversion is running
// BEHAVIOUR
//  Reset (async): o_fnd_com=4'b1111, o_fnd_font=8'hFF, o_overflow=0, o_busy=0. Prescaler=0, digit index=0,
//   display BCD regs=0, FSM=IDLE. Reset mid-conversion aborts the conversion; no partial commit.
//  Prescaler: counts 0..SCAN_DIV-1 and wraps. scan_tick is a 1-cycle pulse on the cycle count==SCAN_DIV-1.
//   Width is $clog2(SCAN_DIV) bits.
//  Digit index: 2-bit counter, advances on scan_tick, wraps 3->0. A frame_start is a scan_tick taken while index==3.
//  Outputs: registered. They update on the cycle after scan_tick to show the new index.
//   o_fnd_com = ~(4'b0001 << index).
//  Font table (hex, active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
//   A blanked digit drives FF.
//  Blanking (LEAD_ZERO_BLANK=1): digit k is blanked when digits k..3 are all zero and k>0.
//   Value 0 shows a single "0" on digit 0.
//  Conversion FSM: IDLE -> CONVERT -> COMMIT -> IDLE.
//   IDLE: on frame_start, sample v = (i_value>9999) ? 9999 : i_value and latch ovf = (i_value>9999).
//    Then go to CONVERT with o_busy=1.
//   CONVERT: 14 cycles. Each cycle first adds 3 to any BCD nibble >= 5, then shifts left by 1,
//    taking in the next MSB of v.
//   COMMIT: 1 cycle. Copies all 16 BCD bits plus ovf to the display regs and o_overflow in a single update,
//    so no frame ever mixes old and new digits. o_busy returns to 0. Next state is IDLE.
//   Latency: the committed value appears 16 cycles after frame_start, i.e. within the slot of digit 0.
//    It is visible on the segment bus from the next scan_tick onward.
//  i_value changes between frame_starts are ignored; only the value sampled at frame_start is displayed.
//  i_enable=0: o_fnd_com=1111 and o_fnd_font=FF on the next cycle. Prescaler and index are held at 0.
//   No new frame_start occurs; a conversion already running completes and commits.
//  i_enable 0->1: prescaler restarts from 0. The first scan_tick after SCAN_DIV cycles selects digit 1.
//   The display shows the last committed value until the next frame_start.
//  SCAN_DIV < 16 is illegal. A conversion must finish within one slot; flag it with a simulation-time $error.
// TESTING  (bench uses SCAN_DIV=20)
//  Reset: assert i_reset mid-CONVERT -> outputs 1111/FF, o_busy=0 in the same cycle; after release, 0 is
//   shown (digit0=C0, others C0).
//  i_value=1234, run 2 frames -> sequence of com/font pairs: 1110/99, 1101/B0, 1011/A4, 0111/F9.
//   Each pair is held 20 cycles.
//  i_value=12000 -> all digits show 90 (9999) and o_overflow=1. Then i_value=5 -> o_overflow=0 after the
//   next COMMIT.
//  LEAD_ZERO_BLANK=1, i_value=40 -> digit0=C0, digit1=99, digit2=FF, digit3=FF. i_value=0 -> only digit0=C0.
//  Change i_value every 3 cycles during a frame -> displayed digits change only at COMMIT, never mid-frame.
//   o_busy is high exactly 15 cycles.
//  Toggle i_enable low for 50 cycles -> 1111/FF within 1 cycle. On re-enable, the first scan_tick lands
//   20 cycles later on digit 1.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed FND driver: scan prescaler, once-per-frame 14-bit to BCD conversion, registered active-low pins.
// Outputs change one cycle after a scan tick; no backpressure, i_value is sampled only at frame start.
module fnd_scan_controller #(
    parameter int SCAN_DIV        = 100_000,
    parameter bit LEAD_ZERO_BLANK = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [13:0] i_value,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font,
    output logic        o_overflow,
    output logic        o_busy
);

    localparam int            PW      = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    logic [PW-1:0] ps_cnt;
    logic [1:0]    digit_idx;
    logic [1:0]    digit_idx_nxt;
    logic          scan_tick;
    logic          frame_start;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    bit_cnt;
    logic [13:0]   bin_sh;
    logic [15:0]   bcd_sh;
    logic [15:0]   bcd_adj;
    logic          ovf_lat;
    logic [15:0]   disp_bcd;

    logic          val_over;
    logic [13:0]   val_clamped;
    logic [3:0]    sel_digit;
    logic          upper_zero;
    logic [7:0]    sel_font;

    function automatic logic [7:0] seg_font(input logic [3:0] d);
        case (d)
            4'd0:    seg_font = 8'hC0;
            4'd1:    seg_font = 8'hF9;
            4'd2:    seg_font = 8'hA4;
            4'd3:    seg_font = 8'hB0;
            4'd4:    seg_font = 8'h99;
            4'd5:    seg_font = 8'h92;
            4'd6:    seg_font = 8'h82;
            4'd7:    seg_font = 8'hF8;
            4'd8:    seg_font = 8'h80;
            4'd9:    seg_font = 8'h90;
            default: seg_font = 8'hFF;
        endcase
    endfunction

    assign scan_tick     = i_enable && (ps_cnt == PS_LAST);
    assign frame_start   = scan_tick && (digit_idx == 2'd3);
    assign digit_idx_nxt = digit_idx + 2'd1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ps_cnt    <= '0;
            digit_idx <= '0;
        end else if (!i_enable) begin
            ps_cnt    <= '0;
            digit_idx <= '0;
        end else if (scan_tick) begin
            ps_cnt    <= '0;
            digit_idx <= digit_idx_nxt;
        end else begin
            ps_cnt    <= ps_cnt + 1'b1;
        end
    end

    // Conversion FSM: state register / next state / outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (frame_start) state_d = S_CONVERT;
            S_CONVERT: if (bit_cnt == 4'd13) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q != S_IDLE);
    end

    assign val_over    = (i_value > 14'd9999);
    assign val_clamped = val_over ? 14'd9999 : i_value;

    always_comb begin
        bcd_adj = bcd_sh;
        for (int n = 0; n < 4; n++) begin
            if (bcd_sh[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_sh[n*4 +: 4] + 4'd3;
        end
    end

    // Display regs change only in COMMIT, so a frame never mixes old and new digits
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bin_sh     <= '0;
            bcd_sh     <= '0;
            bit_cnt    <= '0;
            ovf_lat    <= 1'b0;
            disp_bcd   <= '0;
            o_overflow <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        bin_sh  <= val_clamped;
                        ovf_lat <= val_over;
                        bcd_sh  <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_CONVERT: begin
                    bcd_sh  <= {bcd_adj[14:0], bin_sh[13]};
                    bin_sh  <= {bin_sh[12:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                S_COMMIT: begin
                    disp_bcd   <= bcd_sh;
                    o_overflow <= ovf_lat;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_digit = disp_bcd[{digit_idx_nxt, 2'b00} +: 4];
        case (digit_idx_nxt)
            2'd1:    upper_zero = (disp_bcd[15:4]  == 12'd0);
            2'd2:    upper_zero = (disp_bcd[15:8]  == 8'd0);
            2'd3:    upper_zero = (disp_bcd[15:12] == 4'd0);
            default: upper_zero = 1'b0;
        endcase
        sel_font = (LEAD_ZERO_BLANK && upper_zero) ? 8'hFF : seg_font(sel_digit);
    end

    // Pins are loaded from the digit the tick is about to select
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_fnd_com  <= 4'b1111;
            o_fnd_font <= 8'hFF;
        end else if (!i_enable) begin
            o_fnd_com  <= 4'b1111;
            o_fnd_font <= 8'hFF;
        end else if (scan_tick) begin
            o_fnd_com  <= ~(4'b0001 << digit_idx_nxt);
            o_fnd_font <= sel_font;
        end
    end

    scan_slot_fits: assert property (@(posedge i_clk) disable iff (i_reset)
        !(scan_tick && (state_q != S_IDLE)))
        else $error("fnd_scan_controller: BCD conversion overran a scan slot, SCAN_DIV=%0d must be >= 16", SCAN_DIV);

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: a per-cycle arithmetic model checks two instances (no blanking / blanking)
// while directed scenarios pin slot order, fonts, hold times, overflow, busy length, reset and enable.
module tb_fnd_scan_controller;

    localparam int DIV = 20;
    localparam logic [7:0] FONT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [13:0] val = '0;

    logic [3:0] com0, com1;
    logic [7:0] font0, font1;
    logic       ovf0, ovf1, busy0, busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(.SCAN_DIV(DIV), .LEAD_ZERO_BLANK(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_value(val),
        .o_fnd_com(com0), .o_fnd_font(font0), .o_overflow(ovf0), .o_busy(busy0)
    );

    fnd_scan_controller #(.SCAN_DIV(DIV), .LEAD_ZERO_BLANK(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_value(val),
        .o_fnd_com(com1), .o_fnd_font(font1), .o_overflow(ovf1), .o_busy(busy1)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_font(input int v, input int d, input bit blank);
        int p;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (blank && d > 0 && v < p) return 8'hFF;
        return FONT[(v / p) % 10];
    endfunction

    // Model: run = enabled cycles since restart; slot = run / DIV; a conversion lands 15 edges after frame start
    int         run       = 0;
    int         conv_left = 0;
    int         pend_val  = 0;
    int         disp_val  = 0;
    bit         pend_ovf  = 1'b0;
    bit         disp_ovf  = 1'b0;
    logic [3:0] m_com     = 4'hF;
    logic [7:0] m_font [2] = '{8'hFF, 8'hFF};

    always @(posedge clk or posedge rst) begin
        int shown;
        int dig;
        if (rst) begin
            run = 0; conv_left = 0; disp_val = 0; disp_ovf = 1'b0;
            m_com = 4'hF; m_font[0] = 8'hFF; m_font[1] = 8'hFF;
        end else begin
            shown = disp_val;
            if (conv_left > 0) begin
                conv_left--;
                if (conv_left == 0) begin
                    disp_val = pend_val;
                    disp_ovf = pend_ovf;
                end
            end
            if (!en) begin
                run = 0;
                m_com = 4'hF; m_font[0] = 8'hFF; m_font[1] = 8'hFF;
            end else begin
                if (run % DIV == DIV - 1) begin
                    dig = ((run + 1) / DIV) % 4;
                    m_com = 4'hF;
                    m_com[dig] = 1'b0;
                    m_font[0] = exp_font(shown, dig, 1'b0);
                    m_font[1] = exp_font(shown, dig, 1'b1);
                    if (dig == 0) begin
                        pend_val  = (val > 9999) ? 9999 : int'(val);
                        pend_ovf  = (val > 9999);
                        conv_left = 15;
                    end
                end
                run++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("model_com0",  com0,  m_com);
        check("model_font0", font0, m_font[0]);
        check("model_com1",  com1,  m_com);
        check("model_font1", font1, m_font[1]);
        check("model_ovf0",  ovf0,  disp_ovf);
        check("model_ovf1",  ovf1,  disp_ovf);
        check("model_busy0", busy0, conv_left > 0);
        check("model_busy1", busy1, conv_left > 0);
    end

    function automatic logic [3:0] cur_com(input int w);
        return (w != 0) ? com1 : com0;
    endfunction

    function automatic logic [7:0] cur_font(input int w);
        return (w != 0) ? font1 : font0;
    endfunction

    // Waits for a slot to begin, checks its font, and measures how long it is held
    task automatic slot(input int w, input logic [3:0] exp_com, input logic [7:0] exp_fnt, input string tag);
        int n;
        int held;
        n = 0;
        while (cur_com(w) != exp_com && n < 100) begin @(posedge clk); #1; n++; end
        check({tag, "_com"}, cur_com(w), exp_com);
        check({tag, "_font"}, cur_font(w), exp_fnt);
        held = 0;
        while (cur_com(w) == exp_com && held < 40) begin held++; @(posedge clk); #1; end
        check({tag, "_hold"}, held, DIV);
    endtask

    task automatic sync_frame(input int w);
        int n;
        n = 0;
        while (cur_com(w) != 4'b0111 && n < 100) begin @(posedge clk); #1; n++; end
        n = 0;
        while (cur_com(w) == 4'b0111 && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;

        repeat (3) @(negedge clk);
        check("rst_com", com0, 4'hF);
        check("rst_font", font0, 8'hFF);
        check("rst_ovf", ovf0, 0);
        check("rst_busy", busy0, 0);
        rst = 1'b0;
        val = 14'd1234;

        repeat (2 * 4 * DIV) @(negedge clk);
        sync_frame(0);
        slot(0, 4'b1110, 8'h99, "v1234_d0");
        slot(0, 4'b1101, 8'hB0, "v1234_d1");
        slot(0, 4'b1011, 8'hA4, "v1234_d2");
        slot(0, 4'b0111, 8'hF9, "v1234_d3");

        n = 0;
        while (!busy0 && n < 100) begin @(posedge clk); #1; n++; end
        check("midconv_busy", busy0, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_com", com0, 4'hF);
        check("midrst_font", font0, 8'hFF);
        check("midrst_busy", busy0, 0);
        check("midrst_ovf", ovf0, 0);
        @(negedge clk);
        rst = 1'b0;
        slot(0, 4'b1101, 8'hC0, "postrst_d1");
        slot(0, 4'b1011, 8'hC0, "postrst_d2");
        slot(0, 4'b0111, 8'hC0, "postrst_d3");
        slot(0, 4'b1110, 8'hC0, "postrst_d0");

        @(negedge clk);
        val = 14'd12000;
        repeat (170) @(negedge clk);
        sync_frame(0);
        check("ovf_high", ovf0, 1);
        slot(0, 4'b1110, 8'h90, "ovf_d0");
        slot(0, 4'b1101, 8'h90, "ovf_d1");
        slot(0, 4'b1011, 8'h90, "ovf_d2");
        slot(0, 4'b0111, 8'h90, "ovf_d3");
        @(negedge clk);
        val = 14'd5;
        repeat (170) @(negedge clk);
        check("ovf_low", ovf0, 0);
        check("ovf_low_blank", ovf1, 0);

        @(negedge clk);
        val = 14'd40;
        repeat (170) @(negedge clk);
        sync_frame(1);
        slot(1, 4'b1110, 8'hC0, "blank40_d0");
        slot(1, 4'b1101, 8'h99, "blank40_d1");
        slot(1, 4'b1011, 8'hFF, "blank40_d2");
        slot(1, 4'b0111, 8'hFF, "blank40_d3");
        @(negedge clk);
        val = 14'd0;
        repeat (170) @(negedge clk);
        sync_frame(1);
        slot(1, 4'b1110, 8'hC0, "blank0_d0");
        slot(1, 4'b1101, 8'hFF, "blank0_d1");
        slot(1, 4'b1011, 8'hFF, "blank0_d2");
        slot(1, 4'b0111, 8'hFF, "blank0_d3");

        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    @(negedge clk);
                    val = 14'((i * 1237 + 77) % 16384);
                    repeat (2) @(negedge clk);
                end
            end
            begin
                n = 0;
                while (busy0 && n < 40) begin @(posedge clk); #1; n++; end
                n = 0;
                while (!busy0 && n < 100) begin @(posedge clk); #1; n++; end
                hi = 0;
                while (busy0 && hi < 40) begin hi++; @(posedge clk); #1; end
                check("busy_len", hi, 15);
            end
        join

        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check("dis_com", com0, 4'hF);
        check("dis_font", font0, 8'hFF);
        repeat (50) @(negedge clk);
        en = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (com0 == 4'hF && n < 40);
        check("reen_latency", n, DIV);
        check("reen_com", com0, 4'b1101);

        repeat (100) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
